// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks (sequencer and player checker).
package simon_pkg;

    localparam int NUM_W           = 2;
    localparam int MAX_LEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        CHECK  = 2'd2,
        FAIL   = 2'd3
    } state_e;

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence storage: one synchronous write port, one asynchronous read port, no reset.
module simon_seq_mem #(
    parameter int MAX_LEN = 32,
    parameter int NUM_W   = 2,
    localparam int AW     = $clog2(MAX_LEN)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [NUM_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [NUM_W-1:0] rdata_o
);

    logic [NUM_W-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_player_checker.sv
// Player side of the Simon turn protocol: records the played sequence, then
// checks the player's entries against it in order.
module simon_player_checker #(
    parameter int MAX_LEN = simon_pkg::MAX_LEN_DEFAULT,
    parameter int NUM_W   = simon_pkg::NUM_W,
    localparam int AW     = $clog2(MAX_LEN),
    localparam int CNT_W  = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             simonTurn,
    input  logic [NUM_W-1:0] simonNum,
    input  logic             simonPressed,
    input  logic [NUM_W-1:0] playerNum,
    input  logic             playerPressed,
    output logic [CNT_W-1:0] seqLen,
    output logic [CNT_W-1:0] playerIdx,
    output logic             roundDone,
    output logic             mistake,
    output logic             overflow,
    output logic             busy
);
    import simon_pkg::*;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] seqLen_q, seqLen_d;
    logic [CNT_W-1:0] playerIdx_q, playerIdx_d;
    logic             roundDone_q, roundDone_d;
    logic             mistake_q, mistake_d;
    logic             overflow_q, overflow_d;
    logic             memWe;
    logic [NUM_W-1:0] memRdata;

    simon_seq_mem #(
        .MAX_LEN (MAX_LEN),
        .NUM_W   (NUM_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (memWe),
        .waddr_i (seqLen_q[AW-1:0]),
        .wdata_i (simonNum),
        .raddr_i (playerIdx_q[AW-1:0]),
        .rdata_o (memRdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seqLen_q    <= '0;
            playerIdx_q <= '0;
            roundDone_q <= 1'b0;
            mistake_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seqLen_q    <= seqLen_d;
            playerIdx_q <= playerIdx_d;
            roundDone_q <= roundDone_d;
            mistake_q   <= mistake_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seqLen_d    = seqLen_q;
        playerIdx_d = playerIdx_q;
        roundDone_d = 1'b0;
        mistake_d   = 1'b0;
        overflow_d  = overflow_q;
        memWe       = 1'b0;

        if (state_q != RECORD && simonTurn) begin
            state_d     = RECORD;
            seqLen_d    = '0;
            playerIdx_d = '0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                RECORD: begin
                    if (simonPressed) begin
                        if (seqLen_q < FULL) begin
                            memWe    = 1'b1;
                            seqLen_d = seqLen_q + ONE;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    // A strobe on the falling cycle counts toward the empty-round test.
                    if (!simonTurn) begin
                        playerIdx_d = '0;
                        state_d     = (seqLen_d == '0) ? IDLE : CHECK;
                    end
                end
                CHECK: begin
                    if (playerPressed) begin
                        if (playerNum == memRdata) begin
                            playerIdx_d = playerIdx_q + ONE;
                            if (playerIdx_q == seqLen_q - ONE) begin
                                roundDone_d = 1'b1;
                                state_d     = IDLE;
                            end
                        end else begin
                            mistake_d = 1'b1;
                            state_d   = FAIL;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign seqLen    = seqLen_q;
    assign playerIdx = playerIdx_q;
    assign roundDone = roundDone_q;
    assign mistake   = mistake_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == RECORD) || (state_q == CHECK);

endmodule

// File: tb/tb_simon_player_checker.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_simon_player_checker;

    localparam int MAXL  = 4;
    localparam int NW    = 2;
    localparam int CW    = $clog2(MAXL) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          simonTurn;
    logic [NW-1:0] simonNum;
    logic          simonPressed;
    logic [NW-1:0] playerNum;
    logic          playerPressed;
    logic [CW-1:0] seqLen;
    logic [CW-1:0] playerIdx;
    logic          roundDone;
    logic          mistake;
    logic          overflow;
    logic          busy;

    int passCount  = 0;
    int checkCount = 0;
    bit checkEn    = 1'b0;

    // Model: phase 0 idle, 1 recording, 2 checking, 3 failed
    int mPhase = 0;
    int mSeq[$];
    int mIdx   = 0;
    bit mDone  = 1'b0;
    bit mMis   = 1'b0;
    bit mOvf   = 1'b0;

    simon_player_checker #(
        .MAX_LEN (MAXL),
        .NUM_W   (NW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .simonTurn     (simonTurn),
        .simonNum      (simonNum),
        .simonPressed  (simonPressed),
        .playerNum     (playerNum),
        .playerPressed (playerPressed),
        .seqLen        (seqLen),
        .playerIdx     (playerIdx),
        .roundDone     (roundDone),
        .mistake       (mistake),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour of the game rules, advanced once per rising edge
    always @(posedge clk) begin
        mDone = 1'b0;
        mMis  = 1'b0;
        if (!rst_n) begin
            mPhase = 0;
            mSeq.delete();
            mIdx = 0;
            mOvf = 1'b0;
        end else if (simonTurn && mPhase != 1) begin
            mPhase = 1;
            mSeq.delete();
            mIdx = 0;
            mOvf = 1'b0;
        end else if (mPhase == 1) begin
            if (simonPressed) begin
                if (mSeq.size() < MAXL) mSeq.push_back(int'(simonNum));
                else mOvf = 1'b1;
            end
            if (!simonTurn) begin
                mIdx   = 0;
                mPhase = (mSeq.size() == 0) ? 0 : 2;
            end
        end else if (mPhase == 2 && playerPressed) begin
            if (int'(playerNum) == mSeq[mIdx]) begin
                mIdx++;
                if (mIdx == mSeq.size()) begin
                    mDone  = 1'b1;
                    mPhase = 0;
                end
            end else begin
                mMis   = 1'b1;
                mPhase = 3;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        else
            passCount++;
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("seqLen",    32'(seqLen),    32'(mSeq.size()));
            checkOutput("playerIdx", 32'(playerIdx), 32'(mIdx));
            checkOutput("roundDone", 32'(roundDone), 32'(mDone));
            checkOutput("mistake",   32'(mistake),   32'(mMis));
            checkOutput("overflow",  32'(overflow),  32'(mOvf));
            checkOutput("busy",      32'(busy),      32'(mPhase == 1 || mPhase == 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit turn, input bit sp, input int sn, input bit pp, input int pn);
        simonTurn     = turn;
        simonPressed  = sp;
        simonNum      = NW'(sn);
        playerPressed = pp;
        playerNum     = NW'(pn);
        tick();
    endtask

    task automatic recordSeq(input int vals[$]);
        applyStimulus(1, 0, 0, 0, 0);
        foreach (vals[i]) applyStimulus(1, 1, vals[i], 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rst_n   = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset_seqLen", 32'(seqLen), 0);
        checkOutput("reset_busy",   32'(busy),   0);

        // Record-then-pass
        recordSeq('{2, 0, 3});
        checkOutput("pass_seqLen", 32'(seqLen), 3);
        checkOutput("pass_busy",   32'(busy),   1);
        applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 3);
        checkOutput("pass_roundDone", 32'(roundDone), 1);
        checkOutput("pass_playerIdx", 32'(playerIdx), 3);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pass_doneClear", 32'(roundDone), 0);
        checkOutput("pass_idle",      32'(busy),      0);

        // Mistake, then further entries ignored
        recordSeq('{2, 0, 3});
        applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("mis_pulse",     32'(mistake),   1);
        checkOutput("mis_playerIdx", 32'(playerIdx), 1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 3);
        checkOutput("mis_noPulse", 32'(mistake | roundDone), 0);
        checkOutput("mis_notBusy", 32'(busy), 0);

        // Overflow with 5 strobes into a 4-deep memory
        recordSeq('{0, 1, 2, 3, 1});
        checkOutput("ovf_seqLen", 32'(seqLen),   4);
        checkOutput("ovf_flag",   32'(overflow), 1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 2);
        applyStimulus(0, 0, 0, 1, 3);
        checkOutput("ovf_roundDone", 32'(roundDone), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ovf_cleared", 32'(overflow), 0);

        // Ignored player press in RECORD; strobe and press on the falling cycle
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 2, 1, 1);
        checkOutput("fall_seqLen",    32'(seqLen),    2);
        checkOutput("fall_playerIdx", 32'(playerIdx), 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 2);
        checkOutput("fall_roundDone", 32'(roundDone), 1);

        // Abort mid-CHECK, then an empty round
        recordSeq('{3, 3});
        applyStimulus(0, 0, 0, 1, 3);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("abort_seqLen",    32'(seqLen),    0);
        checkOutput("abort_playerIdx", 32'(playerIdx), 0);
        checkOutput("abort_noPulse",   32'(roundDone | mistake), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("empty_idle", 32'(busy), 0);

        // Reset mid-CHECK with a completing press in the same cycle
        recordSeq('{1, 2});
        applyStimulus(0, 0, 0, 1, 1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 1, 2);
        checkOutput("rst_noPulse",   32'(roundDone), 0);
        checkOutput("rst_playerIdx", 32'(playerIdx), 0);
        checkOutput("rst_busy",      32'(busy),      0);
        rst_n = 1'b1;

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            int pn;
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) < 10) simonTurn = ~simonTurn;
            pn = int'($urandom_range(0, 3));
            if (mPhase == 2 && $urandom_range(0, 99) < 88) pn = mSeq[mIdx];
            applyStimulus(simonTurn, $urandom_range(0, 99) < 40, int'($urandom_range(0, 3)),
                          $urandom_range(0, 99) < 45, pn);
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkEn = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
